wb_serial_master: RTL and testbench
===================================

# wb_serial_master

Wishbone bus initiator driven by a byte stream from a UART receiver, giving the host PC direct word read/write access to every slave on the SoC interconnect (SRAM, block RAM, peripherals) without CPU involvement. It attaches to a free master port of the Wishbone interconnect (e.g. m2) and to the byte-level receive/transmit handshake of a UART instance. Used for bring-up, firmware download into SRAM and register poking while the LM32 is held in reset or running.

## Interface
- `timeout`, 1024: Wishbone cycles to wait for `wb_ack_i`/`wb_err_i` before the transfer is aborted; must be ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_stb` = 1.
- `rx_stb`  in  1  one-cycle pulse per received byte.
- `tx_data`  out  8  byte to transmit; valid while `tx_wr` = 1.
- `tx_wr`  out  1  one-cycle transmit strobe.
- `tx_busy`  in  1  transmitter busy; rises the cycle after `tx_wr` and stays high until the byte has been sent.
- `wb_adr_o`  out  32  byte address.
- `wb_dat_o`  out  32  write data.
- `wb_dat_i`  in  32  read data.
- `wb_sel_o`  out  4  byte selects.
- `wb_we_o`  out  1  write enable.
- `wb_cyc_o`  out  1  bus cycle.
- `wb_stb_o`  out  1  strobe.
- `wb_ack_i`  in  1  slave acknowledge.
- `wb_err_i`  in  1  slave error; tie low if unused.

## Operation
- Protocol, all multi-byte fields MSB first:
  - Write: 0x57 ('W'), 4 address bytes, 4 data bytes. Response: 0x4B ('K').
  - Read: 0x52 ('R'), 4 address bytes. Response: 4 data bytes.
  - Bus error or timeout on either command: single byte 0x45 ('E') instead of the normal response.
- States:
  - IDLE: on `rx_stb` with 0x57 or 0x52, latch the direction and go to ADDR. Any other byte is discarded.
  - ADDR: shift 4 bytes into the address register. Then go to DATA for a write, or BUS for a read.
  - DATA: shift 4 bytes into the write-data register, then go to BUS.
  - BUS: drive a single classic Wishbone cycle.
  - RESP: emit the response bytes, then go to IDLE.
- A 2-bit byte counter serves ADDR, DATA and RESP; it is cleared on every state entry.
- Bus cycle fields: `wb_sel_o` = 4'hF for all transfers (word access only); `wb_we_o` = 1 for writes.
- Read data is captured on the cycle `wb_ack_i` is sampled high.
- Bytes arriving in BUS or RESP are discarded. There is no receive buffering.
- No inter-byte timeout. A partial command waits indefinitely; `reset` is the only recovery.

## Timing
- Reset values: `tx_wr`, `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0; `tx_data`, `wb_adr_o`, `wb_dat_o` = 0; `wb_sel_o` = 4'h0; state IDLE.
- `wb_cyc_o`/`wb_stb_o` rise the cycle after the last command byte's `rx_stb`. They stay high until `wb_ack_i`, `wb_err_i` or timeout, and drop on the following edge.
- `wb_adr_o`, `wb_dat_o` and `wb_we_o` are stable for the whole bus cycle.
- Zero-wait-state slave: cycle 1 in BUS asserts cyc/stb, the ack is seen at the end of cycle 1, and RESP is entered on the next edge.
- `wb_ack_i` and `wb_err_i` high together: treated as error.
- Timeout counter:
  - Width $clog2(timeout), clears on BUS entry and increments each cycle cyc is high.
  - Reaching `timeout`-1 without ack or err aborts the transfer: cyc/stb drop on the next edge and the response is 'E'.
  - An ack in that same cycle wins over the timeout.
- RESP:
  - `tx_wr` pulses in the first cycle with `tx_busy` = 0.
  - The next cycle is a mandatory gap with `tx_wr` = 0 and `tx_busy` ignored; after it, wait for `tx_busy` = 0 again.
  - Back-to-back `tx_wr` is impossible.
- `reset` asserted mid-cycle: cyc/stb and `tx_wr` are 0 on the next edge. The pending command is lost.

## Structure
- Shared package `wb_serial_pkg`:
  - Command codes 0x57 and 0x52.
  - Response codes 0x4B and 0x45.
  - State enum (IDLE, ADDR, DATA, BUS, RESP).
- Single module with no sub-module; shift registers, the byte counter and the timeout counter are local.

## Test plan
- Write: send 57 40 00 00 10 DE AD BE EF, slave acks after 2 waits → one cycle with adr 0x40000010, dat 0xDEADBEEF, sel 0xF, we=1; tx byte 0x4B.
- Read: send 52 00 00 00 04, slave returns 0x12345678 with zero waits → tx bytes 12 34 56 78 in order, each separated by a busy period plus gap.
- Timeout: `timeout`=16, read with no ack → cyc drops exactly 16 cycles after rising; tx 0x45; the next command works.
- Error and garbage: slave asserts `wb_err_i` → tx 0x45. Stray bytes 0x00 and 0xFF in IDLE → no bus cycle and no tx.
- Reset mid-cycle: assert `reset` while cyc=1 → cyc, stb and tx_wr are 0 next cycle, state IDLE; a subsequent full write completes normally.

Source files
------------

// File: rtl/wb_serial_pkg.sv
// Shared command/response codes and state encoding for the UART-driven Wishbone initiator.
package wb_serial_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  // Byte idx of a word, MSB first (idx 0 = bits 31:24).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wb_serial_master.sv
// Wishbone initiator fed by a UART byte stream: 'W' a a a a d d d d -> 'K', 'R' a a a a -> d d d d,
// bus error or timeout -> 'E'.
module wb_serial_master
  import wb_serial_pkg::*;
#(
  parameter int timeout = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int            TW      = $clog2(timeout);
  localparam logic [TW-1:0] TO_LAST = TW'(timeout - 1);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic          cyc_q, cyc_d;
  logic          err_q, err_d;
  logic          gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic          start_bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rdat_d    = rdat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    cyc_d     = cyc_q;
    err_d     = err_q;
    gap_d     = gap_q;
    to_d      = to_q;
    start_bus = 1'b0;
    tx_wr     = 1'b0;
    tx_data   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (rx_stb && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          we_d    = (rx_data == CMD_WRITE);
          cnt_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_stb) begin
          adr_d = {adr_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d = '0;
            if (we_q) state_d = ST_DATA;
            else      start_bus = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (rx_stb) begin
          dat_d = {dat_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d     = '0;
            start_bus = 1'b1;
          end
        end
      end
      ST_BUS: begin
        to_d = to_q + TW'(1);
        // An ack on the final timeout cycle still completes the transfer.
        if (wb_ack_i || wb_err_i || to_q == TO_LAST) begin
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
          err_d   = wb_err_i || !wb_ack_i;
          cnt_d   = '0;
          gap_d   = 1'b0;
          state_d = ST_RESP;
          if (wb_ack_i && !wb_err_i) rdat_d = wb_dat_i;
        end
      end
      ST_RESP: begin
        if (err_q)     tx_data = RSP_ERR;
        else if (we_q) tx_data = RSP_ACK;
        else           tx_data = word_byte(rdat_q, cnt_q);
        // The cycle after each strobe is a forced gap so tx_busy has time to rise.
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (!tx_busy) begin
          tx_wr = 1'b1;
          gap_d = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (err_q || we_q || cnt_q == 2'd3) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_bus) begin
      state_d = ST_BUS;
      cyc_d   = 1'b1;
      sel_d   = 4'hF;
      to_d    = '0;
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed + randomized bench for wb_serial_master with a memory-backed slave and a UART tx model.
module tb_wb_serial_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_stb;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_viol  = 0;
  int sl_mode  = 0;  // 0 ack, 1 err, 2 silent, 3 ack+err
  int sl_waits = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  logic [7:0]  txq [$];
  logic [31:0] bus_adr_q [$];
  logic [31:0] bus_dat_q [$];
  logic        bus_we_q  [$];
  logic [3:0]  bus_sel_q [$];
  int          bus_len_q [$];
  logic        bus_bad_q [$];
  logic [31:0] addrs [$];

  wb_serial_master #(.timeout(16)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  // Wishbone slave: records each cycle and answers after sl_waits wait states.
  initial begin
    int len;
    logic bad, w;
    logic [31:0] a, d;
    logic [3:0] s;
    len = 0; bad = 1'b0; w = 1'b0; a = '0; d = '0; s = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o) begin
        if (len == 0) begin
          a = wb_adr_o; d = wb_dat_o; w = wb_we_o; s = wb_sel_o; bad = 1'b0;
        end else if (wb_adr_o !== a || wb_dat_o !== d || wb_we_o !== w || wb_sel_o !== s) begin
          bad = 1'b1;
        end
        if (wb_stb_o !== 1'b1) bad = 1'b1;
        len++;
        if (sl_mode != 2 && len == sl_waits + 1) begin
          wb_ack_i = (sl_mode == 0 || sl_mode == 3);
          wb_err_i = (sl_mode == 1 || sl_mode == 3);
          if (!w) wb_dat_i = mem.exists(a) ? mem[a] : 32'h0;
          else if (sl_mode == 0) mem[a] = d;
        end
      end else if (len != 0) begin
        bus_adr_q.push_back(a); bus_dat_q.push_back(d); bus_we_q.push_back(w);
        bus_sel_q.push_back(s); bus_len_q.push_back(len); bus_bad_q.push_back(bad);
        len = 0;
      end
    end
  end

  // UART transmitter: busy from the cycle after tx_wr for a random number of cycles.
  initial begin
    int bcnt;
    logic prev;
    bcnt = 0; prev = 1'b0; tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_wr) begin
        txq.push_back(tx_data);
        if (prev || tx_busy) tx_viol++;
      end
      prev = tx_wr;
      @(posedge clk);
      #1;
      if (prev) bcnt = $urandom_range(2, 6);
      else if (bcnt > 0) bcnt--;
      tx_busy = (bcnt > 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic issue(input logic is_w, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(is_w ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
    if (is_w) for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8]);
  endtask

  task automatic clear_bus();
    bus_adr_q.delete(); bus_dat_q.delete(); bus_we_q.delete();
    bus_sel_q.delete(); bus_len_q.delete(); bus_bad_q.delete();
  endtask

  // Reference: one bus cycle of the expected shape, then 'K', 'E' or the word MSB first.
  task automatic finish_txn(input string tag, input logic is_w, input logic [31:0] adr,
                            input logic [31:0] dat, input int mode, input int waits);
    logic [7:0] exp_b [$];
    logic [31:0] w;
    int exp_len;
    exp_len = (mode == 2) ? 16 : waits + 1;
    if (mode != 0) exp_b.push_back(8'h45);
    else if (is_w) begin
      exp_b.push_back(8'h4B);
      exp_mem[adr] = dat;
    end else begin
      w = exp_mem.exists(adr) ? exp_mem[adr] : 32'h0;
      for (int i = 3; i >= 0; i--) exp_b.push_back(w[8*i +: 8]);
    end
    for (int i = 0; i < 100 && bus_len_q.size() == 0; i++) @(negedge clk);
    chk({tag, "/bus_cycles"}, bus_len_q.size(), 1);
    if (bus_len_q.size() > 0) begin
      chk({tag, "/adr"}, bus_adr_q[0], adr);
      if (is_w) chk({tag, "/dat"}, bus_dat_q[0], dat);
      chk({tag, "/we"}, bus_we_q[0], is_w);
      chk({tag, "/sel"}, bus_sel_q[0], 4'hF);
      chk({tag, "/cyc_len"}, bus_len_q[0], exp_len);
      chk({tag, "/stable"}, bus_bad_q[0], 1'b0);
    end
    for (int i = 0; i < 400 && txq.size() < exp_b.size(); i++) @(negedge clk);
    repeat (12) @(negedge clk);
    chk({tag, "/rsp_count"}, txq.size(), exp_b.size());
    foreach (exp_b[i]) if (txq.size() > 0) chk({tag, "/rsp_byte"}, txq.pop_front(), exp_b[i]);
    txq.delete();
    clear_bus();
  endtask

  task automatic do_txn(input string tag, input logic is_w, input logic [31:0] adr,
                        input logic [31:0] dat, input int mode, input int waits);
    sl_mode  = mode;
    sl_waits = waits;
    issue(is_w, adr, dat);
    finish_txn(tag, is_w, adr, dat, mode, waits);
  endtask

  initial begin
    logic [31:0] a, d;
    logic w;
    int m, wt;
    reset = 1'b1; rx_stb = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst/cyc", wb_cyc_o, 1'b0);
    chk("rst/stb", wb_stb_o, 1'b0);
    chk("rst/we", wb_we_o, 1'b0);
    chk("rst/sel", wb_sel_o, 4'h0);
    chk("rst/adr", wb_adr_o, 32'h0);
    chk("rst/dat", wb_dat_o, 32'h0);
    chk("rst/tx_wr", tx_wr, 1'b0);
    chk("rst/tx_data", tx_data, 8'h00);
    reset = 1'b0;

    mem[32'h4] = 32'h12345678;
    exp_mem[32'h4] = 32'h12345678;

    do_txn("write", 1'b1, 32'h40000010, 32'hDEADBEEF, 0, 2);
    do_txn("read", 1'b0, 32'h4, 32'h0, 0, 0);
    chk("read/tx_protocol", tx_viol, 0);
    do_txn("timeout", 1'b0, 32'h4, 32'h0, 2, 0);
    do_txn("after_timeout", 1'b0, 32'h40000010, 32'h0, 0, 1);
    do_txn("err", 1'b1, 32'h100, 32'h55, 1, 1);
    do_txn("ack_err", 1'b0, 32'h4, 32'h0, 3, 0);
    do_txn("ack_at_limit", 1'b0, 32'h4, 32'h0, 0, 15);

    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (20) @(negedge clk);
    chk("garbage/bus_cycles", bus_len_q.size(), 0);
    chk("garbage/tx_bytes", txq.size(), 0);
    do_txn("after_garbage", 1'b1, 32'h200, 32'hA5A5_0F0F, 0, 0);

    // A command byte arriving mid-cycle must be dropped.
    sl_mode = 0; sl_waits = 8;
    issue(1'b1, 32'h300, 32'h0BAD_CAFE);
    send_byte(8'h52);
    finish_txn("stray_in_bus", 1'b1, 32'h300, 32'h0BAD_CAFE, 0, 8);
    do_txn("after_stray", 1'b0, 32'h300, 32'h0, 0, 0);

    sl_mode = 2;
    issue(1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 20 && !wb_cyc_o; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst/cyc", wb_cyc_o, 1'b0);
    chk("midrst/stb", wb_stb_o, 1'b0);
    chk("midrst/tx_wr", tx_wr, 1'b0);
    reset = 1'b0;
    repeat (24) @(negedge clk);
    chk("midrst/tx_bytes", txq.size(), 0);
    txq.delete();
    clear_bus();
    do_txn("post_rst_write", 1'b1, 32'h40000020, 32'hCAFEF00D, 0, 1);
    do_txn("post_rst_read", 1'b0, 32'h40000020, 32'h0, 0, 2);

    for (int k = 0; k < 16; k++) begin
      w = (addrs.size() == 0) || ($urandom_range(0, 1) == 1);
      if (w) begin
        a = $urandom & 32'hFFFF_FFFC;
        d = $urandom;
        addrs.push_back(a);
      end else begin
        a = addrs[$urandom_range(0, addrs.size() - 1)];
        d = 32'h0;
      end
      m  = ($urandom_range(0, 4) == 0) ? 1 : 0;
      wt = $urandom_range(0, 4);
      do_txn("rand", w, a, d, m, wt);
    end
    chk("tx_protocol", tx_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
